// File: rtl/audio_tx_buffer.sv
// Stereo sample FIFO between a producer and a codec write port.
// Holds off streaming until a prefill level is reached, then issues one write per write_ready.
module audio_tx_buffer #(
  parameter int N       = 3,
  parameter int PREFILL = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               in_valid,
  input  logic signed [23:0] in_left,
  input  logic signed [23:0] in_right,
  output logic               in_ready,
  input  logic               write_ready,
  output logic               write,
  output logic signed [23:0] writedata_left,
  output logic signed [23:0] writedata_right,
  output logic [N:0]         level,
  output logic [15:0]        underrun_count,
  output logic [15:0]        overflow_count
);

  localparam int DEPTH = 1 << N;

  typedef enum logic {
    ST_PREFILL,
    ST_STREAM
  } state_t;

  state_t             state_q, state_d;
  logic [47:0]        mem_q [DEPTH];
  logic [N-1:0]       wr_ptr_q, wr_ptr_d;
  logic [N-1:0]       rd_ptr_q, rd_ptr_d;
  logic [N:0]         level_q, level_d;
  logic               write_q, write_d;
  logic signed [23:0] wd_left_q, wd_left_d;
  logic signed [23:0] wd_right_q, wd_right_d;
  logic [15:0]        underrun_q, underrun_d;
  logic [15:0]        overflow_q, overflow_d;
  logic               full, empty, push, pop, underrun;

  always_comb begin
    full       = (level_q == (N+1)'(DEPTH));
    empty      = (level_q == '0);
    in_ready   = enable & ~full;
    push       = in_valid & in_ready;
    pop        = 1'b0;
    underrun   = 1'b0;
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    write_d    = 1'b0;
    wd_left_d  = wd_left_q;
    wd_right_d = wd_right_q;
    underrun_d = underrun_q;
    overflow_d = overflow_q;

    if (!enable) begin
      state_d    = ST_PREFILL;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      wd_left_d  = '0;
      wd_right_d = '0;
    end else begin
      if (state_q == ST_PREFILL) begin
        if (level_q >= (N+1)'(PREFILL)) state_d = ST_STREAM;
      end else if (write_ready) begin
        // Emptiness is judged before this edge's push, so no pass-through.
        write_d = 1'b1;
        if (!empty) begin
          pop                     = 1'b1;
          {wd_left_d, wd_right_d} = mem_q[rd_ptr_q];
        end else begin
          underrun = 1'b1;
        end
      end

      if (push) wr_ptr_d = wr_ptr_q + N'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + N'(1);
      if (push && !pop)      level_d = level_q + (N+1)'(1);
      else if (pop && !push) level_d = level_q - (N+1)'(1);

      if (in_valid && full && (overflow_q != '1)) overflow_d = overflow_q + 16'd1;
      if (underrun && (underrun_q != '1))         underrun_d = underrun_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_PREFILL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      write_q    <= 1'b0;
      wd_left_q  <= '0;
      wd_right_q <= '0;
      underrun_q <= '0;
      overflow_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      write_q    <= write_d;
      wd_left_q  <= wd_left_d;
      wd_right_q <= wd_right_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push) mem_q[wr_ptr_q] <= {in_left, in_right};
  end

  assign write           = write_q;
  assign writedata_left  = wd_left_q;
  assign writedata_right = wd_right_q;
  assign level           = level_q;
  assign underrun_count  = underrun_q;
  assign overflow_count  = overflow_q;

endmodule

// File: tb/tb_audio_tx_buffer.sv
// Directed bench for audio_tx_buffer: expected write pairs are queued by the stimulus
// and a negedge monitor checks every write strobe against the queue.
module tb_audio_tx_buffer;

  logic               clock = 1'b0;
  logic               reset, enable, in_valid, write_ready;
  logic signed [23:0] in_left, in_right;
  logic               in_ready, write;
  logic signed [23:0] writedata_left, writedata_right;
  logic [3:0]         level;
  logic [15:0]        underrun_count, overflow_count;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  audio_tx_buffer #(.N(3), .PREFILL(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .in_valid        (in_valid),
    .in_left         (in_left),
    .in_right        (in_right),
    .in_ready        (in_ready),
    .write_ready     (write_ready),
    .write           (write),
    .writedata_left  (writedata_left),
    .writedata_right (writedata_right),
    .level           (level),
    .underrun_count  (underrun_count),
    .overflow_count  (overflow_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int v);
    in_left  = 24'(v);
    in_right = 24'(-v);
  endtask

  // Monitor: every write strobe must match the head of the expectation queue.
  always @(negedge clock) begin
    if (write) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_left", int'(writedata_left), 0);
        total++;
        bad++;
        $display("FAIL unexpected_write actual=1 required=0 at %0t", $time);
      end else begin
        int v;
        v = exp_q.pop_front();
        chk("wr_left", int'(writedata_left), v);
        chk("wr_right", int'(writedata_right), -v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; write_ready = 1'b0;
    drive(0);
    step(); step();
    reset = 1'b0;
    chk("rst_write", int'(write), 0);
    chk("rst_wd_left", int'(writedata_left), 0);
    chk("rst_wd_right", int'(writedata_right), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_underrun", int'(underrun_count), 0);
    chk("rst_overflow", int'(overflow_count), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // Prefill: no writes until level reaches 4, then 1..4 on consecutive cycles.
    write_ready = 1'b1;
    for (int v = 1; v <= 4; v++) exp_q.push_back(v);
    for (int v = 1; v <= 4; v++) begin
      in_valid = 1'b1; drive(v);
      step();
      chk("pf_level", int'(level), v);
      chk("pf_no_write", int'(write), 0);
    end
    in_valid = 1'b0;
    step();
    chk("pf_entry_no_write", int'(write), 0);
    chk("pf_entry_level", int'(level), 4);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("pf_write", int'(write), 1);
      chk("pf_drain_level", int'(level), 4 - i);
    end
    write_ready = 1'b0;
    step();
    chk("pf_underrun", int'(underrun_count), 0);

    // Underrun: last real write (5,-5), then three repeats.
    for (int i = 0; i < 4; i++) exp_q.push_back(5);
    in_valid = 1'b1; drive(5);
    step();
    in_valid = 1'b0; write_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ur_write", int'(write), 1);
    end
    write_ready = 1'b0;
    chk("ur_count", int'(underrun_count), 3);
    chk("ur_level", int'(level), 0);

    // Overflow: 10 pushes into depth 8 with the output stalled.
    for (int v = 11; v <= 20; v++) begin
      in_valid = 1'b1; drive(v);
      step();
      if (v == 18) begin
        chk("ov_full_level", int'(level), 8);
        chk("ov_in_ready", int'(in_ready), 0);
      end
    end
    in_valid = 1'b0;
    chk("ov_count", int'(overflow_count), 2);
    chk("ov_level", int'(level), 8);
    for (int v = 11; v <= 18; v++) exp_q.push_back(v);
    write_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    write_ready = 1'b0;
    chk("ov_drained_level", int'(level), 0);
    chk("ov_underrun_hold", int'(underrun_count), 3);

    // Wrap-around: 20 pairs, steady level 3 with simultaneous push/pop.
    for (int v = 101; v <= 120; v++) exp_q.push_back(v);
    for (int v = 101; v <= 103; v++) begin
      in_valid = 1'b1; drive(v);
      step();
    end
    write_ready = 1'b1;
    for (int v = 104; v <= 120; v++) begin
      in_valid = 1'b1; drive(v);
      step();
      chk("wr_level_steady", int'(level), 3);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    write_ready = 1'b0;
    chk("wrap_level", int'(level), 0);
    chk("wrap_underrun", int'(underrun_count), 3);

    // Flush: one cycle of enable low discards buffered pairs.
    for (int v = 201; v <= 202; v++) begin
      in_valid = 1'b1; drive(v);
      step();
    end
    in_valid = 1'b0;
    enable = 1'b0;
    #1;
    chk("fl_in_ready", int'(in_ready), 0);
    step();
    enable = 1'b1;
    chk("fl_level", int'(level), 0);
    chk("fl_write", int'(write), 0);
    chk("fl_wd_left", int'(writedata_left), 0);
    chk("fl_wd_right", int'(writedata_right), 0);
    chk("fl_underrun", int'(underrun_count), 3);
    chk("fl_overflow", int'(overflow_count), 2);
    write_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("fl_prefill_no_write", int'(write), 0);
    end
    write_ready = 1'b0;

    // Reset mid-stream: one pair written, the rest discarded.
    exp_q.push_back(301);
    for (int v = 301; v <= 304; v++) begin
      in_valid = 1'b1; drive(v);
      step();
    end
    in_valid = 1'b0;
    step();
    write_ready = 1'b1;
    step();
    chk("rs_write_before", int'(write), 1);
    reset = 1'b1;
    step();
    chk("rs_write", int'(write), 0);
    chk("rs_wd_left", int'(writedata_left), 0);
    chk("rs_wd_right", int'(writedata_right), 0);
    chk("rs_level", int'(level), 0);
    chk("rs_underrun", int'(underrun_count), 0);
    chk("rs_overflow", int'(overflow_count), 0);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rs_no_write", int'(write), 0);
    end
    write_ready = 1'b0;
    step();
    chk("exp_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
